mdu_seq: RTL
============

# mdu_seq

Iterative multiply/divide unit for the MIPS datapath, producing the HI/LO register pair for MULT, MULTU, DIV and DIVU. It sits directly downstream of the carry-lookahead adder chain. Each of its 32 iteration steps reuses one 33-bit add/subtract to perform a shift-add (multiply) or a restoring shift-subtract (divide). The decode stage stalls on `busy`; MFHI/MFLO read `hi`/`lo`; MTHI/MTLO write them through the `wr_*` ports.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Iteration count equals `WIDTH`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch an operation. Sampled only in IDLE.
- `op` in 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (multiplicand / dividend). Captured on accepted `start`.
- `b` in WIDTH: rt operand (multiplier / divisor). Captured on accepted `start`.
- `wr_hi` in 1: MTHI write strobe.
- `wr_lo` in 1: MTLO write strobe.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when `hi`/`lo` hold the new result.
- `div_zero` out 1: one-cycle pulse coincident with `done` for DIV/DIVU when `b` is 0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: on `start`, capture operands and go to CALC; counter = 0.
  - CALC: 32 cycles; at the end of the cycle with counter = 31, go to FIX.
  - FIX: 1 cycle; go to IDLE.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes in IDLE.
  - FIX negates the result as required:
    - Product: negated when the operand signs differ.
    - Quotient: negated when the operand signs differ.
    - Remainder: takes the sign of the dividend.
- Multiply: accumulator {acc[32:0], lo}. Each step:
  - If lo[0] is set, add the multiplicand to acc.
  - Shift right one bit.
  - Result is 64 bits: HI holds the upper word, LO the lower word.
- Divide: restoring divide. Each step:
  - Shift {rem, quo} left.
  - Trial-subtract the divisor.
  - Keep the difference and set the quotient bit if it is non-negative.
  - Result: LO = quotient, HI = remainder.
- Divide by zero: iteration is skipped but latency is unchanged. Result is HI = `a`, LO = 0xFFFFFFFF, and `div_zero` pulses with `done`.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of 32-bit wrap.
- `hi`/`lo` are updated only at the end of FIX. They hold their previous values throughout the operation.
- `wr_hi`/`wr_lo`:
  - Honoured only in IDLE; the value is visible the next cycle.
  - Ignored while `busy`.
  - `wr_*` together with `start` in IDLE: the write lands and the operation is accepted. The later result overwrites the written value.
- `start` while `busy`: ignored.
- `start` in the cycle that `done` is high: accepted, because the state is IDLE.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, state = IDLE, counter = 0.
- Cycle schedule, with `start` sampled at edge 0:
  - `busy` is high in cycles 1–33.
  - CALC occupies cycles 1–32.
  - FIX occupies cycle 33.
  - Cycle 34: `done` = 1, `hi`/`lo` hold the new result, `busy` = 0.
- Latency: 34 cycles from start to result; a back-to-back issue interval of 34.
- `rst` mid-operation aborts the operation. On the next cycle every output takes its reset value, and no `done` is emitted.
- All outputs are registered.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as described above.
- `MDU_DIV_EN` undefined:
  - The divide datapath is removed.
  - `start` with op[1] = 1 is ignored: no `busy`, no `done`, HI/LO unchanged.
  - `div_zero` is tied to 0.
  - Multiply behaviour and timing are unchanged.

## Structure
- Shared package `mdu_pkg` holds:
  - `op` encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings: S_IDLE, S_CALC, S_FIX.
  - Iteration count constant.
- One sub-module, `mdu_addsub`: a 33-bit add/subtract, with `sub` selecting a + ~b + 1. It is shared by both the multiply and divide step logic.
- The FSM, counter, shift registers and sign fix stay in `mdu_seq`.

## Test plan
- MULT, a = 0xFFFFFFFD (−3), b = 5 -> cycle 34 `done`, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU, a = b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; `busy` is high for exactly 33 cycles.
- DIV, a = 0xFFFFFFF9 (−7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU, a = 100, b = 0 -> hi = 0x64, lo = 0xFFFFFFFF, `div_zero` and `done` pulse together. With `MDU_DIV_EN` undefined, the same stimulus produces no `busy`, and hi/lo are unchanged.
- `wr_hi` = 1, `wdata` = 0x1234 in IDLE -> hi = 0x1234 next cycle. The same `wr_hi` issued during CALC -> hi is unchanged. A second `start` during CALC is ignored.
- `rst` asserted in cycle 10 of a MULTU -> all outputs are 0 the next cycle, no `done`, and a new `start` is accepted afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the iterative multiply/divide unit
// Contents: op select encodings, FSM state encodings, default iteration count.
package mdu_pkg;

   // Operation select driven on mdu_seq.op
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // One iteration per operand bit
   localparam int MDU_ITERS = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_addsub.sv
// rtl/mdu_addsub.sv - W-bit adder/subtractor shared by the multiply and divide steps
// Ports:
//   a, b : operands
//   sub  : 0 -> y = a + b, 1 -> y = a + ~b + 1
//   y    : result, carry out discarded
module mdu_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   assign y = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MIPS multiply/divide unit producing the HI/LO pair
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, op, a, b    : launch MULT/MULTU/DIV/DIVU (op 00/01/10/11) with rs/rt operands
//   wr_hi, wr_lo, wdata: MTHI/MTLO writes, honoured only while idle
//   busy               : operation in flight
//   done, div_zero     : one-cycle result pulse; div_zero flags a zero divisor
//   hi, lo             : HI/LO registers
// Build option: MDU_DIV_EN enables DIV/DIVU; without it divide starts are ignored.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   mdu_state_e         state, state_next;
   logic [CW-1:0]      cnt;

   // acc: upper product half (plus carry) / partial remainder
   // qreg: multiplier shifting out into the low product / dividend shifting into quotient
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   qreg;
   logic [WIDTH-1:0]   mcand;
   logic               neg_q;

   logic               accept;
   logic               signed_op;
   logic               step_en;
   logic [WIDTH-1:0]   a_mag, b_mag;

   logic [WIDTH:0]     as_a, as_b, as_y;
   logic               as_sub;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     acc_step;
   logic [WIDTH-1:0]   q_step;

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   hi_fix, lo_fix;

`ifdef MDU_DIV_EN
   logic               is_div;
   logic               neg_r;
   logic               dz;
   logic [WIDTH-1:0]   a_raw;

   assign accept  = (state == S_IDLE) && start;
   assign step_en = !dz;
`else
   assign accept  = (state == S_IDLE) && start && ((op == OP_MULT) || (op == OP_MULTU));
   assign step_en = 1'b1;
`endif

   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != S_IDLE);
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (accept) state_next = S_CALC;
         S_CALC:  if (cnt == CNT_LAST) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- shared add/subtract ----------------
   always_comb begin
      as_sub = 1'b0;
      as_a   = acc;
`ifdef MDU_DIV_EN
      if (is_div) begin
         // Trial subtract against the remainder shifted left with the next dividend bit
         as_sub = 1'b1;
         as_a   = {acc[WIDTH-1:0], qreg[WIDTH-1]};
      end
`endif
   end

   assign as_b = {1'b0, mcand};

   mdu_addsub #(.W(WIDTH + 1)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .y   (as_y)
   );

   // ---------------- per-step next values ----------------
   always_comb begin
      mul_sum  = qreg[0] ? as_y : acc;
      acc_step = {1'b0, mul_sum[WIDTH:1]};
      q_step   = {mul_sum[0], qreg[WIDTH-1:1]};
`ifdef MDU_DIV_EN
      if (is_div) begin
         // Negative difference (top bit set) means the divisor did not fit: restore
         if (as_y[WIDTH]) begin
            acc_step = as_a;
            q_step   = {qreg[WIDTH-2:0], 1'b0};
         end else begin
            acc_step = as_y;
            q_step   = {qreg[WIDTH-2:0], 1'b1};
         end
      end
`endif
   end

   // ---------------- sign fix of the final result ----------------
   always_comb begin
      prod     = {acc[WIDTH-1:0], qreg};
      prod_fix = neg_q ? -prod : prod;
      hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
      if (is_div) begin
         if (dz) begin
            hi_fix = a_raw;
            lo_fix = '1;
         end else begin
            hi_fix = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            lo_fix = neg_q ? -qreg : qreg;
         end
      end
`endif
   end

   // ---------------- datapath and HI/LO ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         acc   <= '0;
         qreg  <= '0;
         mcand <= '0;
         neg_q <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
         if (accept) begin
            cnt   <= '0;
            acc   <= '0;
            neg_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
            qreg  <= op[1] ? a_mag : b_mag;
            mcand <= op[1] ? b_mag : a_mag;
`else
            qreg  <= b_mag;
            mcand <= a_mag;
`endif
         end
         if (state == S_CALC) begin
            cnt <= cnt + CW'(1);
            if (step_en) begin
               acc  <= acc_step;
               qreg <= q_step;
            end
         end
         if (state == S_FIX) begin
            hi   <= hi_fix;
            lo   <= lo_fix;
            done <= 1'b1;
         end
      end
   end

`ifdef MDU_DIV_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div   <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
         a_raw    <= '0;
         div_zero <= 1'b0;
      end else begin
         div_zero <= 1'b0;
         if (accept) begin
            is_div <= op[1];
            neg_r  <= signed_op && a[WIDTH-1];
            dz     <= op[1] && (b == '0);
            a_raw  <= a;
         end
         if (state == S_FIX) div_zero <= is_div && dz;
      end
   end
`else
   assign div_zero = 1'b0;
`endif

endmodule
